// File: rtl/cellrv32_bus_initiator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cellrv32_bus_initiator_if                                       |
// | Purpose: Processor-internal bus between the load/store initiator and     |
// |          the bus responders (DMEM, IO devices).                          |
// | Signals (named from the initiator's point of view):                      |
// |   bus_rden_o   read strobe (one cycle)                                   |
// |   bus_wren_o   write strobe (one cycle)                                  |
// |   bus_ben_o    byte enables                                              |
// |   bus_addr_o   byte address                                              |
// |   bus_data_o   lane-replicated write data                                |
// |   bus_ticket_o request ticket (1..15)                                    |
// |   bus_data_i   response data, zero when no responder is selected         |
// |   bus_ticket_i response ticket, 0 from unselected responders             |
// |   bus_ack_i    transfer acknowledge                                      |
// |   bus_err_i    transfer error                                            |
// | Modports: master (initiator side), slave (responder side)                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface cellrv32_bus_initiator_if;
  logic        bus_rden_o;
  logic        bus_wren_o;
  logic [3:0]  bus_ben_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [3:0]  bus_ticket_o;
  logic [31:0] bus_data_i;
  logic [3:0]  bus_ticket_i;
  logic        bus_ack_i;
  logic        bus_err_i;

  modport master (
    output bus_rden_o, bus_wren_o, bus_ben_o, bus_addr_o, bus_data_o, bus_ticket_o,
    input  bus_data_i, bus_ticket_i, bus_ack_i, bus_err_i
  );

  modport slave (
    input  bus_rden_o, bus_wren_o, bus_ben_o, bus_addr_o, bus_data_o, bus_ticket_o,
    output bus_data_i, bus_ticket_i, bus_ack_i, bus_err_i
  );
endinterface
`default_nettype wire

// File: rtl/cellrv32_bus_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : cellrv32_bus_initiator                                          |
// | Purpose: Single-outstanding load/store bus initiator. Checks alignment,  |
// |          builds byte enables and lane-replicated write data, issues a    |
// |          one-cycle ticketed read/write strobe, waits for the matching    |
// |          response and returns realigned, extended read data.             |
// | Parameters:                                                              |
// |   BUS_TIMEOUT  WAIT cycles before abort (1..1023), timeout build only    |
// | Build option:                                                            |
// |   CELLRV32_BUS_TIMEOUT_EN  define to enable the WAIT-state timeout       |
// | Ports:                                                                   |
// |   clk_i, rstn_i              clock, asynchronous active-low reset        |
// |   req_i, we_i, size_i,       CPU request (sampled only in IDLE)          |
// |   unsigned_i, addr_i, wdata_i                                            |
// |   busy_o, done_o, rdata_o    status, completion pulse, load result       |
// |   bus_err_o, misalign_o,     completion qualifiers (pulse with done_o)   |
// |   timeout_o                                                              |
// |   bus                        initiator side of the processor bus         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module cellrv32_bus_initiator #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        timeout_o,
  cellrv32_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ticket_q, ticket_d;
  logic        rden_q, rden_d;
  logic        wren_q, wren_d;
  logic [3:0]  ben_q, ben_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;
`ifdef CELLRV32_BUS_TIMEOUT_EN
  localparam logic [9:0] TIMEOUT_LAST = 10'(BUS_TIMEOUT - 1);
  logic        to_q, to_d;
  logic [9:0]  cnt_q, cnt_d;
`endif

  logic        misaligned;
  logic [3:0]  ben_new;
  logic [31:0] wdata_new;
  logic [31:0] rdata_aligned;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [3:0]  ticket_inc;
  logic        resp_ack;
  logic        resp_err;

  // Request decode: alignment, byte enables, replicated store data.
  always_comb begin
    misaligned = 1'b0;
    ben_new    = 4'b1111;
    wdata_new  = wdata_i;
    case (size_i)
      2'b00: begin
        ben_new   = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = addr_i[0];
        ben_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new  = {2{wdata_i[15:0]}};
      end
      default: begin
        misaligned = (addr_i[1:0] != 2'b00);
      end
    endcase
  end

  // Load realignment uses the latched request, not the live CPU inputs.
  always_comb begin
    lane_b        = 8'h00;
    lane_h        = addr_q[1] ? bus.bus_data_i[31:16] : bus.bus_data_i[15:0];
    rdata_aligned = bus.bus_data_i;
    case (addr_q[1:0])
      2'd0:    lane_b = bus.bus_data_i[7:0];
      2'd1:    lane_b = bus.bus_data_i[15:8];
      2'd2:    lane_b = bus.bus_data_i[23:16];
      default: lane_b = bus.bus_data_i[31:24];
    endcase
    case (size_q)
      2'b00:   rdata_aligned = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   rdata_aligned = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: rdata_aligned = bus.bus_data_i;
    endcase
  end

  // Ticket 0 is reserved for "no responder", so the counter skips it.
  assign ticket_inc = (ticket_q == 4'd15) ? 4'd1 : ticket_q + 4'd1;

  // Only responses carrying our ticket count; anything else is stale.
  assign resp_ack = bus.bus_ack_i & (bus.bus_ticket_i == ticket_q);
  assign resp_err = bus.bus_err_i & (bus.bus_ticket_i == ticket_q);

  always_comb begin
    state_d  = state_q;
    ticket_d = ticket_q;
    rden_d   = 1'b0;
    wren_d   = 1'b0;
    ben_d    = ben_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    mis_d    = 1'b0;
`ifdef CELLRV32_BUS_TIMEOUT_EN
    to_d     = 1'b0;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          if (misaligned) begin
            // Completion is flagged on entry so done_o shows in the FAULT cycle.
            state_d = S_FAULT;
            done_d  = 1'b1;
            mis_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = S_ISSUE;
            rden_d  = ~we_i;
            wren_d  = we_i;
            ben_d   = ben_new;
            addr_d  = addr_i;
            wdata_d = wdata_new;
            we_d    = we_i;
            size_d  = size_i;
            uns_d   = unsigned_i;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef CELLRV32_BUS_TIMEOUT_EN
        cnt_d   = 10'd0;
`endif
      end
      S_WAIT: begin
        if (resp_err) begin
          state_d  = S_IDLE;
          ticket_d = ticket_inc;
          done_d   = 1'b1;
          err_d    = 1'b1;
          rdata_d  = 32'h0;
        end else if (resp_ack) begin
          state_d  = S_IDLE;
          ticket_d = ticket_inc;
          done_d   = 1'b1;
          rdata_d  = we_q ? 32'h0 : rdata_aligned;
        end
`ifdef CELLRV32_BUS_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d  = S_IDLE;
          ticket_d = ticket_inc;
          done_d   = 1'b1;
          to_d     = 1'b1;
          rdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
`endif
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      ticket_q <= 4'd1;
      rden_q   <= 1'b0;
      wren_q   <= 1'b0;
      ben_q    <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
`ifdef CELLRV32_BUS_TIMEOUT_EN
      to_q     <= 1'b0;
      cnt_q    <= 10'd0;
`endif
    end else begin
      state_q  <= state_d;
      ticket_q <= ticket_d;
      rden_q   <= rden_d;
      wren_q   <= wren_d;
      ben_q    <= ben_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      size_q   <= size_d;
      uns_q    <= uns_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
`ifdef CELLRV32_BUS_TIMEOUT_EN
      to_q     <= to_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign rdata_o          = rdata_q;
  assign bus_err_o        = err_q;
  assign misalign_o       = mis_q;
`ifdef CELLRV32_BUS_TIMEOUT_EN
  assign timeout_o        = to_q;
`else
  // No timeout hardware: legal BUS_TIMEOUT values are positive, so this is 0.
  assign timeout_o        = (BUS_TIMEOUT < 0);
`endif
  assign bus.bus_rden_o   = rden_q;
  assign bus.bus_wren_o   = wren_q;
  assign bus.bus_ben_o    = ben_q;
  assign bus.bus_addr_o   = addr_q;
  assign bus.bus_data_o   = wdata_q;
  assign bus.bus_ticket_o = ticket_q;

endmodule
`default_nettype wire

// File: tb/tb_cellrv32_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_cellrv32_bus_initiator                                       |
// | Purpose: Self-checking bench for cellrv32_bus_initiator with a simple    |
// |          ticket-echoing responder and a byte-level reference model.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cellrv32_bus_initiator;
`ifdef CELLRV32_BUS_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam int MAX_DLY    = 2;
`else
  localparam int TB_TIMEOUT = 255;
  localparam int MAX_DLY    = 5;
`endif

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        unsigned_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        busy_o, done_o, bus_err_o, misalign_o, timeout_o;
  logic [31:0] rdata_o;

  cellrv32_bus_initiator_if bus ();

  cellrv32_bus_initiator #(.BUS_TIMEOUT(TB_TIMEOUT)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o),
    .done_o(done_o), .rdata_o(rdata_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o),
    .timeout_o(timeout_o), .bus(bus.master)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int exp_ticket = 1;

  typedef struct {
    int          s_cyc;
    int          d_cyc;
    int          n_strb;
    logic        s_we;
    logic [3:0]  s_ben;
    logic [31:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_tkt;
    logic [31:0] r_data;
    logic        r_err;
    logic        r_mis;
    logic        r_to;
    logic        r_busy;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_ben(input logic [1:0] sz, input logic [31:0] a);
    logic [3:0] b;
    int n, lo;
    n = nbytes(sz);
    lo = int'(a % 4);
    for (int i = 0; i < 4; i++) b[i] = (i >= lo) && (i < lo + n);
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] a, input logic [31:0] d);
    longint unsigned v, span;
    int n;
    n = nbytes(sz);
    if (n == 4) return d;
    span = 64'd1 << (8 * n);
    v = {32'd0, d};
    v = (v >> (8 * (a % 4))) % span;
    if (!uns && v >= span / 2) v = v + (64'h1_0000_0000 - span);
    return v[31:0];
  endfunction

  function automatic int next_ticket(input int t);
    return (t == 15) ? 1 : t + 1;
  endfunction

  // ---------------- stimulus driver (no checking) ----------------
  task automatic clear_resp();
    bus.bus_ack_i = 1'b0;
    bus.bus_err_i = 1'b0;
    bus.bus_ticket_i = 4'd0;
    bus.bus_data_i = 32'h0;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    req_i = 1'b0;
    clear_resp();
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    exp_ticket = 1;
  endtask

  // Issues one request and plays a responder that echoes the ticket
  // dly cycles after a registered ack would arrive (dly<0: never answers).
  task automatic run_txn(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly, output obs_t o);
    int ack_cyc;
    o = '{s_cyc: -1, d_cyc: -1, n_strb: 0, s_we: 0, s_ben: 0, s_addr: 0, s_data: 0,
          s_tkt: 0, r_data: 0, r_err: 0, r_mis: 0, r_to: 0, r_busy: 0};
    ack_cyc = -1;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; addr_i = a; wdata_i = wd;
    for (int c = 1; c <= 1200; c++) begin
      @(posedge clk_i); #1;
      if (c == 1) req_i = 1'b0;
      clear_resp();
      if (bus.bus_rden_o || bus.bus_wren_o) begin
        o.n_strb++;
        if (o.s_cyc < 0) begin
          o.s_cyc  = c;
          o.s_we   = bus.bus_wren_o;
          o.s_ben  = bus.bus_ben_o;
          o.s_addr = bus.bus_addr_o;
          o.s_data = bus.bus_data_o;
          o.s_tkt  = bus.bus_ticket_o;
          if (dly >= 0) ack_cyc = c + 1 + dly;
        end
      end
      if (done_o) begin
        o.d_cyc  = c;
        o.r_data = rdata_o;
        o.r_err  = bus_err_o;
        o.r_mis  = misalign_o;
        o.r_to   = timeout_o;
        o.r_busy = busy_o;
        break;
      end
      if (c == ack_cyc) begin
        bus.bus_ack_i = 1'b1;
        bus.bus_ticket_i = o.s_tkt;
        bus.bus_data_i = o.s_we ? 32'h0 : rd;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++;
      $display("FAIL reset_status: got done=%b busy=%b expected 0 0", done_o, busy_o); end
    n_cmp++; if ({bus_err_o, misalign_o, timeout_o, bus.bus_rden_o, bus.bus_wren_o} !== 5'b0) begin n_err++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus_err_o, misalign_o, timeout_o, bus.bus_rden_o, bus.bus_wren_o}); end
    n_cmp++; if (rdata_o !== 32'h0 || bus.bus_addr_o !== 32'h0 || bus.bus_data_o !== 32'h0 || bus.bus_ben_o !== 4'h0) begin n_err++;
      $display("FAIL reset_data: got rdata=%h addr=%h data=%h ben=%b expected zeros",
               rdata_o, bus.bus_addr_o, bus.bus_data_o, bus.bus_ben_o); end
    n_cmp++; if (bus.bus_ticket_o !== 4'd1) begin n_err++;
      $display("FAIL reset_ticket: got %0d expected 1", bus.bus_ticket_o); end
  endtask

  task automatic test_word_load();
    obs_t o;
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 0, o);
    n_cmp++; if (o.s_cyc !== 1 || o.s_ben !== 4'b1111 || o.s_we !== 1'b0) begin n_err++;
      $display("FAIL word_strobe: got cyc=%0d ben=%b we=%b expected 1 1111 0", o.s_cyc, o.s_ben, o.s_we); end
    n_cmp++; if (o.s_tkt !== 4'(exp_ticket) || o.s_addr !== 32'h8) begin n_err++;
      $display("FAIL word_ticket_addr: got %0d/%h expected %0d/%h", o.s_tkt, o.s_addr, exp_ticket, 32'h8); end
    n_cmp++; if (o.d_cyc !== 3 || o.r_busy !== 1'b0) begin n_err++;
      $display("FAIL word_done: got cyc=%0d busy=%b expected 3 0", o.d_cyc, o.r_busy); end
    n_cmp++; if (o.r_data !== 32'hDEAD_BEEF) begin n_err++;
      $display("FAIL word_rdata: got %h expected %h", o.r_data, 32'hDEAD_BEEF); end
    exp_ticket = next_ticket(exp_ticket);
    n_cmp++; if (bus.bus_ticket_o !== 4'(exp_ticket)) begin n_err++;
      $display("FAIL word_next_ticket: got %0d expected %0d", bus.bus_ticket_o, exp_ticket); end
  endtask

  task automatic test_byte_load();
    obs_t o;
    run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, o);
    exp_ticket = next_ticket(exp_ticket);
    n_cmp++; if (o.r_data !== 32'hFFFF_FF80 || o.s_ben !== 4'b1000) begin n_err++;
      $display("FAIL byte_signed: got %h ben=%b expected ffffff80 1000", o.r_data, o.s_ben); end
    run_txn(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1, o);
    exp_ticket = next_ticket(exp_ticket);
    n_cmp++; if (o.r_data !== 32'h0000_0080 || o.d_cyc !== 4) begin n_err++;
      $display("FAIL byte_unsigned: got %h cyc=%0d expected 00000080 4", o.r_data, o.d_cyc); end
  endtask

  task automatic test_half_store();
    obs_t o;
    run_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hABCD_1234, 32'h0, 0, o);
    exp_ticket = next_ticket(exp_ticket);
    n_cmp++; if (o.s_ben !== 4'b1100 || o.s_data !== 32'h1234_1234) begin n_err++;
      $display("FAIL half_store_lanes: got ben=%b data=%h expected 1100 12341234", o.s_ben, o.s_data); end
    n_cmp++; if (o.n_strb !== 1 || o.s_we !== 1'b1) begin n_err++;
      $display("FAIL half_store_strobe: got count=%0d we=%b expected 1 1", o.n_strb, o.s_we); end
    n_cmp++; if (o.d_cyc !== 3 || o.r_data !== 32'h0 || o.r_err !== 1'b0) begin n_err++;
      $display("FAIL half_store_done: got cyc=%0d rdata=%h err=%b expected 3 0 0", o.d_cyc, o.r_data, o.r_err); end
  endtask

  task automatic test_misalign_and_tickets();
    obs_t o;
    do_reset();
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h1234_5678, 0, o);
    n_cmp++; if (o.n_strb !== 0 || o.d_cyc !== 1 || o.r_mis !== 1'b1 || o.r_data !== 32'h0) begin n_err++;
      $display("FAIL misalign: got strobes=%0d cyc=%0d mis=%b rdata=%h expected 0 1 1 0",
               o.n_strb, o.d_cyc, o.r_mis, o.r_data); end
    n_cmp++; if (bus.bus_ticket_o !== 4'd1) begin n_err++;
      $display("FAIL misalign_ticket: got %0d expected 1", bus.bus_ticket_o); end
    for (int i = 0; i < 16; i++) begin
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4000 + 32'(4 * i), 32'h0, 32'(i), 0, o);
      n_cmp++; if (o.s_tkt !== 4'((i % 15) + 1)) begin n_err++;
        $display("FAIL ticket_seq[%0d]: got %0d expected %0d", i, o.s_tkt, (i % 15) + 1); end
      exp_ticket = next_ticket(exp_ticket);
    end
    n_cmp++; if (bus.bus_ticket_o !== 4'd2) begin n_err++;
      $display("FAIL ticket_after_wrap: got %0d expected 2", bus.bus_ticket_o); end
  endtask

  task automatic test_stale_and_err();
    logic [3:0] tkt;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h40;
    @(posedge clk_i); #1;                       // strobe cycle
    tkt = bus.bus_ticket_o;
    n_cmp++; if (bus.bus_rden_o !== 1'b1 || tkt !== 4'(exp_ticket)) begin n_err++;
      $display("FAIL stale_issue: got rden=%b tkt=%0d expected 1 %0d", bus.bus_rden_o, tkt, exp_ticket); end
    we_i = 1'b1; addr_i = 32'h80;               // request while busy must be dropped
    @(posedge clk_i); #1;                       // WAIT: stale ack, ticket 0
    bus.bus_ack_i = 1'b1; bus.bus_ticket_i = 4'd0; bus.bus_data_i = 32'h1111_1111;
    @(posedge clk_i); #1;
    n_cmp++; if (done_o !== 1'b0) begin n_err++;
      $display("FAIL stale_ticket0: got done=%b expected 0", done_o); end
    bus.bus_err_i = 1'b1; bus.bus_ticket_i = 4'(next_ticket(int'(tkt)));
    @(posedge clk_i); #1;
    n_cmp++; if (done_o !== 1'b0 || bus.bus_wren_o !== 1'b0 || bus.bus_ticket_o !== tkt) begin n_err++;
      $display("FAIL stale_wrong_ticket: got done=%b wren=%b tkt=%0d expected 0 0 %0d",
               done_o, bus.bus_wren_o, bus.bus_ticket_o, tkt); end
    req_i = 1'b0;
    bus.bus_ack_i = 1'b1; bus.bus_err_i = 1'b1; bus.bus_ticket_i = tkt; bus.bus_data_i = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    clear_resp();
    n_cmp++; if (done_o !== 1'b1 || bus_err_o !== 1'b1 || rdata_o !== 32'h0 || busy_o !== 1'b0) begin n_err++;
      $display("FAIL ack_err_same_cycle: got done=%b err=%b rdata=%h busy=%b expected 1 1 0 0",
               done_o, bus_err_o, rdata_o, busy_o); end
    exp_ticket = next_ticket(exp_ticket);
    @(posedge clk_i); #1;
    n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++;
      $display("FAIL done_pulse_width: got done=%b busy=%b expected 0 0", done_o, busy_o); end
  endtask

  task automatic test_random();
    obs_t o;
    logic we, uns;
    logic [1:0] sz;
    logic [31:0] a, wd, rd;
    int dly;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
      a = $urandom; wd = $urandom; rd = $urandom;
      if ((i % 2) == 0) a[1:0] = 2'b00;
      dly = int'($urandom_range(MAX_DLY, 0));
      run_txn(we, sz, uns, a, wd, rd, dly, o);
      if (m_misaligned(sz, a)) begin
        n_cmp++; if (o.n_strb !== 0 || o.d_cyc !== 1 || o.r_mis !== 1'b1 || o.r_data !== 32'h0) begin n_err++;
          $display("FAIL rnd_misalign[%0d]: got strobes=%0d cyc=%0d mis=%b rdata=%h expected 0 1 1 0",
                   i, o.n_strb, o.d_cyc, o.r_mis, o.r_data); end
      end else begin
        n_cmp++; if (o.n_strb !== 1 || o.s_we !== we || o.s_ben !== m_ben(sz, a) || o.s_addr !== a || o.s_tkt !== 4'(exp_ticket)) begin n_err++;
          $display("FAIL rnd_issue[%0d]: got n=%0d we=%b ben=%b addr=%h tkt=%0d expected 1 %b %b %h %0d",
                   i, o.n_strb, o.s_we, o.s_ben, o.s_addr, o.s_tkt, we, m_ben(sz, a), a, exp_ticket); end
        if (we) begin
          n_cmp++; if (o.s_data !== m_wdata(sz, wd)) begin n_err++;
            $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, o.s_data, m_wdata(sz, wd)); end
        end
        n_cmp++; if (o.d_cyc !== 3 + dly || o.r_data !== (we ? 32'h0 : m_rdata(sz, uns, a, rd)) || o.r_mis !== 1'b0) begin n_err++;
          $display("FAIL rnd_done[%0d]: got cyc=%0d rdata=%h mis=%b expected %0d %h 0",
                   i, o.d_cyc, o.r_data, o.r_mis, 3 + dly, we ? 32'h0 : m_rdata(sz, uns, a, rd)); end
        exp_ticket = next_ticket(exp_ticket);
      end
    end
  endtask

`ifdef CELLRV32_BUS_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'h0, -1, o);
    n_cmp++; if (o.d_cyc !== 2 + TB_TIMEOUT || o.r_to !== 1'b1 || o.r_data !== 32'h0 || o.r_err !== 1'b0) begin n_err++;
      $display("FAIL timeout: got cyc=%0d to=%b rdata=%h err=%b expected %0d 1 0 0",
               o.d_cyc, o.r_to, o.r_data, o.r_err, 2 + TB_TIMEOUT); end
    exp_ticket = next_ticket(exp_ticket);
  endtask
`endif

  task automatic test_reset_mid_wait();
    obs_t o;
    logic [3:0] tkt;
    @(posedge clk_i); #1;
    req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h100;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    tkt = bus.bus_ticket_o;
    @(posedge clk_i); #1;                       // in WAIT
    rstn_i = 1'b0;
    #1;
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0 || rdata_o !== 32'h0 || {bus.bus_rden_o, bus.bus_wren_o} !== 2'b00) begin n_err++;
      $display("FAIL rst_wait_outputs: got busy=%b done=%b rdata=%h strobes=%b expected 0 0 0 00",
               busy_o, done_o, rdata_o, {bus.bus_rden_o, bus.bus_wren_o}); end
    n_cmp++; if (bus.bus_ticket_o !== 4'd1 || bus.bus_ben_o !== 4'h0 || bus.bus_addr_o !== 32'h0) begin n_err++;
      $display("FAIL rst_wait_bus: got tkt=%0d ben=%b addr=%h expected 1 0000 0",
               bus.bus_ticket_o, bus.bus_ben_o, bus.bus_addr_o); end
    exp_ticket = 1;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    bus.bus_ack_i = 1'b1; bus.bus_ticket_i = tkt; bus.bus_data_i = 32'h5555_AAAA;
    @(posedge clk_i); #1;
    clear_resp();
    @(posedge clk_i); #1;
    n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++;
      $display("FAIL late_ack_after_reset: got done=%b busy=%b expected 0 0", done_o, busy_o); end
    run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'hBEEF_0000, 0, o);
    n_cmp++; if (o.s_tkt !== 4'd1 || o.r_data !== 32'h0000_BEEF) begin n_err++;
      $display("FAIL post_reset_txn: got tkt=%0d rdata=%h expected 1 0000beef", o.s_tkt, o.r_data); end
    exp_ticket = next_ticket(exp_ticket);
  endtask

  initial begin
    clear_resp();
    #3;
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misalign_and_tickets();
    test_stale_and_err();
    test_random();
`ifdef CELLRV32_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cellrv32_bus_initiator.md
# cellrv32_bus_initiator

Processor-internal bus initiator connecting the CPU load/store path to the bus responders (DMEM, IO devices). Accepts one load/store request at a time and checks alignment. Generates byte enables and lane-replicated write data, then issues a single-cycle read or write strobe tagged with a 4-bit ticket. Waits for the matching acknowledge or error, then returns realigned, sign- or zero-extended read data with a one-cycle completion pulse.

## Interface
Parameters:
- BUS_TIMEOUT, default 255: WAIT-state cycles before abort (used only with the timeout feature; legal 1..1023).

Ports:
- clk_i  in  1  global clock, rising edge
- rstn_i  in  1  asynchronous reset, active-low
- req_i  in  1  request strobe; sampled only in IDLE
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_i  in  1  load zero-extend (1) / sign-extend (0)
- addr_i  in  32  byte address
- wdata_i  in  32  store data, right-aligned
- busy_o  out  1  high while not IDLE
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  load result, valid with done_o, held until the next done_o
- bus_err_o  out  1  pulse with done_o: responder error
- misalign_o  out  1  pulse with done_o: misaligned request, no bus access
- timeout_o  out  1  pulse with done_o: no response within BUS_TIMEOUT
- bus_rden_o  out  1  read strobe
- bus_wren_o  out  1  write strobe
- bus_ben_o  out  4  byte enables
- bus_addr_o  out  32  address, word lane bits as issued
- bus_data_o  out  32  write data
- bus_ticket_o  out  4  request ticket
- bus_data_i  in  32  response data; zero when the responder is not selected
- bus_ticket_i  in  4  response ticket; 0 from unselected responders
- bus_ack_i  in  1  transfer acknowledge
- bus_err_i  in  1  transfer error

## Operation
- FSM states: IDLE, ISSUE, WAIT, FAULT.
- IDLE:
  - req_i with an aligned request: latch request, register bus outputs, go to ISSUE.
  - req_i with a misaligned request: go to FAULT.
  - req_i while busy_o=1: ignored, not queued.
- Misaligned: half with addr_i[0]=1; word with addr_i[1:0]≠00. Byte is never misaligned.
- ISSUE: exactly one cycle with bus_rden_o (load) or bus_wren_o (store) high, then WAIT.
- WAIT: bus_addr_o, bus_ben_o, bus_data_o and bus_ticket_o are held stable. Strobes are low.
  - Response counts only if bus_ticket_i == bus_ticket_o. Non-matching ack/err is ignored (stale).
  - Matching bus_err_i: done_o + bus_err_o, rdata_o=0.
  - Matching bus_ack_i without err: done_o, rdata_o = realigned data (0 for stores).
  - Either response returns to IDLE.
- FAULT: one cycle, done_o + misalign_o, rdata_o=0, no strobe, ticket unchanged, back to IDLE.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<(2*addr[1])
  - word: 1111
- Write data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
- Read data: lane selected by addr[1:0] (byte) or addr[1] (half), then sign/zero extended per unsigned_i. Word is passed through.
- Ticket: 4-bit counter, reset value 1, increments on each ISSUE, wraps 15→1 (0 is never issued).
- Simultaneous matching ack and err in the same cycle: err wins.
- Responses in IDLE/ISSUE/FAULT: ignored.

## Timing
- Reset values: all outputs 0 except bus_ticket_o=1; state IDLE.
- Responder with registered ack (ack one cycle after strobe):
  - cycle 0: req_i
  - cycle 1: strobe
  - cycle 2: ack
  - cycle 3: done_o
  - Request-to-done = 3 cycles. Next req_i accepted in cycle 3 (busy_o low in the done_o cycle).
- Misaligned: done_o in cycle 1.
- done_o, rdata_o and error flags are registered. No combinational path from bus inputs to CPU outputs.
- Reset asserted mid-transaction: immediate return to IDLE, strobes low, ticket=1. A late response after reset is ignored.

## Configuration
- CELLRV32_BUS_TIMEOUT_EN defined:
  - A 10-bit counter clears on entering WAIT and counts WAIT cycles.
  - When the count reaches BUS_TIMEOUT with no matching response: done_o + timeout_o, rdata_o=0, IDLE.
  - A matching response in the same cycle as expiry wins over the timeout.
- Not defined: no counter; WAIT lasts until a matching response arrives; timeout_o is tied 0.

## Test plan
- Word load, addr 0x0000_0008, responder returns 0xDEADBEEF with ticket 1 -> strobe with ben 1111 in cycle 1, done_o in cycle 3, rdata_o=0xDEADBEEF, next bus_ticket_o=2.
- Byte loads at 0x...0003 on data 0x80FF_0000: signed -> 0xFFFFFF80; unsigned -> 0x00000080; ben=1000.
- Half store 0x1234 at 0x...0002 -> bus_ben_o=1100, bus_data_o=0x12341234, wren for exactly 1 cycle, done_o with rdata_o=0.
- Word load at 0x...0001 -> no strobe, done_o + misalign_o in cycle 1, ticket unchanged. Then 16 aligned loads -> ticket sequence 1..15,1,2 (never 0).
- Stale ack with ticket 0 during WAIT -> ignored. Matching ack and err in the same cycle -> bus_err_o=1, rdata_o=0.
- With CELLRV32_BUS_TIMEOUT_EN and BUS_TIMEOUT=4, no response -> done_o + timeout_o after 4 WAIT cycles. rstn_i pulsed in WAIT -> all outputs 0, ticket=1, later ack ignored.
